// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   - state_t       : controller states IDLE / RUN / DONE
//   - OP_MUL/OP_DIV : encodings of the op input
//   - DEFAULT_WIDTH : default operand width of the unit
//   - COUNT_W       : iteration counter width for the default width
// Optional feature macro used by the unit: MULDIV_DIV_EN (divide datapath).
// ---------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam int DEFAULT_WIDTH = 16;
   localparam int COUNT_W       = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Purely combinational single iteration of the shared multiply/divide loop.
//   isDiv    in   1      selects restoring-divide step instead of add-shift
//   operand  in   WIDTH  multiplicand (multiply) or divisor (divide)
//   hiIn     in   WIDTH  upper accumulator half / partial remainder
//   loIn     in   WIDTH  lower accumulator half (multiplier bits / dividend
//                        bits on the way in, quotient bits on the way out)
//   hiOut    out  WIDTH  next upper half
//   loOut    out  WIDTH  next lower half
// ---------------------------------------------------------------------------
module muldiv_step #(
   parameter int WIDTH = 16
) (
   input  logic             isDiv,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] hiIn,
   input  logic [WIDTH-1:0] loIn,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut
);

   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShifted;
   logic [WIDTH-1:0] divTrial;
   logic             divNoBorrow;

   // Multiply: the current LSB of the multiplier (sitting in loIn[0]) decides
   // whether the multiplicand is added into the upper half; the whole
   // accumulator then shifts right one place, so the carry drops into the
   // upper half and the low bit of the sum enters the product's lower half.
   // Divide: the partial remainder (one bit wider than an operand) takes the
   // next dividend bit from the top of loIn. The trial difference only needs
   // its low WIDTH bits, because whenever it is kept it is below the divisor.
   always_comb begin
      mulSum      = {1'b0, hiIn} + (loIn[0] ? {1'b0, operand} : '0);
      divShifted  = {hiIn, loIn[WIDTH-1]};
      divNoBorrow = (divShifted >= {1'b0, operand});
      divTrial    = divShifted[WIDTH-1:0] - operand;

      hiOut = mulSum[WIDTH:1];
      loOut = {mulSum[0], loIn[WIDTH-1:1]};
      if (isDiv) begin
         hiOut = divNoBorrow ? divTrial : divShifted[WIDTH-1:0];
         loOut = {loIn[WIDTH-2:0], divNoBorrow};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative unsigned multiply / restoring divide, WIDTH iterations per
// request under a start/busy/done handshake.
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous active-high reset
//   start        in   1      request, accepted in IDLE or DONE
//   op           in   1      0 = multiply, 1 = divide
//   operand_a    in   WIDTH  multiplicand / dividend
//   operand_b    in   WIDTH  multiplier / divisor
//   busy         out  1      high while iterating
//   done         out  1      one-cycle pulse, results valid
//   result_hi    out  WIDTH  product upper half / remainder
//   result_lo    out  WIDTH  product lower half / quotient
//   div_by_zero  out  1      divide request had a zero divisor
// Optional feature: define MULDIV_DIV_EN to include the divide datapath.
// Without it op is ignored, every request multiplies, div_by_zero is 0.
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   localparam int CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

   state_t           state;
   state_t           nextState;
   logic             accept;
   logic             lastIter;
   logic [CntW-1:0]  count;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] accHi;
   logic [WIDTH-1:0] accLo;
   logic [WIDTH-1:0] stepHi;
   logic [WIDTH-1:0] stepLo;
   logic [WIDTH-1:0] stepOperand;
   logic             opIsDiv;
   logic             acceptAsDiv;

`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0] opB;

   // Divide-only state: the divisor and the op are captured on the accepting
   // edge so the upstream mux may move on. The zero-divisor flag is decided
   // from the captured divisor and only changes when a result is published.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         opB         <= '0;
         opIsDiv     <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            opB     <= operand_b;
            opIsDiv <= (op == OP_DIV);
         end
         if (lastIter) begin
            div_by_zero <= opIsDiv && (opB == '0);
         end
      end
   end

   assign acceptAsDiv = (op == OP_DIV);
   assign stepOperand = opIsDiv ? opB : opA;
`else
   assign opIsDiv     = 1'b0;
   assign acceptAsDiv = 1'b0;
   assign stepOperand = opA;
   assign div_by_zero = 1'b0;
`endif

   muldiv_step #(
      .WIDTH (WIDTH)
   ) stepInst (
      .isDiv   (opIsDiv),
      .operand (stepOperand),
      .hiIn    (accHi),
      .loIn    (accLo),
      .hiOut   (stepHi),
      .loOut   (stepLo)
   );

   // State register of the controller; reset drops straight back to IDLE,
   // abandoning any iteration in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A request is accepted from IDLE and also from DONE so
   // that back-to-back operations need no idle cycle; start while running is
   // deliberately not looked at. lastIter marks the edge that finishes the
   // final iteration and publishes the result.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      lastIter  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            if (count == LastCount) begin
               lastIter  = 1'b1;
               nextState = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               nextState = RUN;
            end else begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Shared datapath registers. On acceptance the accumulator is cleared and
   // the lower half is loaded with the multiplier (multiply) or the dividend
   // (divide), which the step logic then consumes one bit per cycle. The
   // visible results are written only on the final iteration edge, so they
   // stay stable from one done pulse to the next.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count     <= '0;
         opA       <= '0;
         accHi     <= '0;
         accLo     <= '0;
         result_hi <= '0;
         result_lo <= '0;
      end else begin
         if (accept) begin
            count <= '0;
            opA   <= operand_a;
            accHi <= '0;
            accLo <= acceptAsDiv ? operand_a : operand_b;
         end else if (state == RUN) begin
            count <= count + 1'b1;
            accHi <= stepHi;
            accLo <= stepLo;
            if (lastIter) begin
               result_hi <= stepHi;
               result_lo <= stepLo;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit: handshake timing, multiply and divide
// results, zero divisor, start ignored while running, asynchronous reset
// abort and back-to-back requests. Expected values are worked out by hand;
// divide vectors expect multiply results when MULDIV_DIV_EN is not defined.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic        op;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic        busy;
   logic        done;
   logic [15:0] result_hi;
   logic [15:0] result_lo;
   logic        div_by_zero;

   int checks;
   int errors;

   muldiv_unit dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents a request and holds start across exactly one rising edge;
   // called just after an edge, returns 1 unit after the accepting edge.
   task automatic applyStimulus(input logic opIn, input logic [15:0] a,
                                input logic [15:0] b);
      op        = opIn;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Waits a bounded number of edges for done and checks the latency; an
   // expired bound reports latency as all-ones so the check fails.
   task automatic waitDone(input string tag, input int expectedCycles);
      int seen;
      seen = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (done) begin
            seen = n;
            break;
         end
      end
      checkOutput({tag, "_latency"}, 32'(seen), 32'(expectedCycles));
      checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
   endtask

   // Watchdog against a stuck simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneCount;
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      op        = 1'b0;
      operand_a = '0;
      operand_b = '0;

      // Reset state
      #2;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_hi", {16'd0, result_hi}, 32'd0);
      checkOutput("rst_lo", {16'd0, result_lo}, 32'd0);
      checkOutput("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // 3 * 5
      applyStimulus(1'b0, 16'd3, 16'd5);
      checkOutput("mul1_busy_after_e0", {31'd0, busy}, 32'd1);
      waitDone("mul1", 16);
      checkOutput("mul1_hi", {16'd0, result_hi}, 32'h0000);
      checkOutput("mul1_lo", {16'd0, result_lo}, 32'h000F);
      checkOutput("mul1_dbz", {31'd0, div_by_zero}, 32'd0);
      @(posedge clock);
      #1;
      checkOutput("mul1_done_one_cycle", {31'd0, done}, 32'd0);
      checkOutput("mul1_lo_held", {16'd0, result_lo}, 32'h000F);

      // 0xFFFF * 0xFFFF
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
      waitDone("mul2", 16);
      checkOutput("mul2_hi", {16'd0, result_hi}, 32'hFFFE);
      checkOutput("mul2_lo", {16'd0, result_lo}, 32'h0001);

      // 100 / 7
      applyStimulus(1'b1, 16'd100, 16'd7);
      waitDone("div1", 16);
`ifdef MULDIV_DIV_EN
      checkOutput("div1_hi", {16'd0, result_hi}, 32'h0002);
      checkOutput("div1_lo", {16'd0, result_lo}, 32'h000E);
`else
      checkOutput("div1_hi", {16'd0, result_hi}, 32'h0000);
      checkOutput("div1_lo", {16'd0, result_lo}, 32'h02BC);
`endif
      checkOutput("div1_dbz", {31'd0, div_by_zero}, 32'd0);

      // 0x1234 / 0
      applyStimulus(1'b1, 16'h1234, 16'h0000);
      waitDone("div0", 16);
`ifdef MULDIV_DIV_EN
      checkOutput("div0_hi", {16'd0, result_hi}, 32'h1234);
      checkOutput("div0_lo", {16'd0, result_lo}, 32'hFFFF);
      checkOutput("div0_dbz", {31'd0, div_by_zero}, 32'd1);
`else
      checkOutput("div0_hi", {16'd0, result_hi}, 32'h0000);
      checkOutput("div0_lo", {16'd0, result_lo}, 32'h0000);
      checkOutput("div0_dbz", {31'd0, div_by_zero}, 32'd0);
`endif

      // 2 * 3 with a second request and new operands while running
      applyStimulus(1'b0, 16'd2, 16'd3);
      repeat (4) @(posedge clock);
      #1;
      operand_a = 16'd9;
      operand_b = 16'd9;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start     = 1'b0;
      operand_a = 16'hAAAA;
      operand_b = 16'h5555;
      checkOutput("ign_busy", {31'd0, busy}, 32'd1);
      waitDone("ign", 11);
      checkOutput("ign_hi", {16'd0, result_hi}, 32'h0000);
      checkOutput("ign_lo", {16'd0, result_lo}, 32'h0006);
      checkOutput("ign_dbz", {31'd0, div_by_zero}, 32'd0);

      // Reset in the middle of a multiply
      @(posedge clock);
      #1;
      applyStimulus(1'b0, 16'h00FF, 16'h0101);
      repeat (8) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_hi", {16'd0, result_hi}, 32'd0);
      checkOutput("abort_lo", {16'd0, result_lo}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #1;
         if (done) doneCount++;
      end
      checkOutput("abort_no_done", 32'(doneCount), 32'd0);

      // Normal request after the abort, then a back-to-back one from DONE
      applyStimulus(1'b0, 16'd7, 16'd6);
      waitDone("post", 16);
      checkOutput("post_lo", {16'd0, result_lo}, 32'h002A);
      checkOutput("post_hi", {16'd0, result_hi}, 32'h0000);
      applyStimulus(1'b0, 16'h0100, 16'h0100);
      checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
      checkOutput("b2b_done", {31'd0, done}, 32'd0);
      waitDone("b2b", 16);
      checkOutput("b2b_hi", {16'd0, result_hi}, 32'h0001);
      checkOutput("b2b_lo", {16'd0, result_lo}, 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
